// File: rtl/mycpu_pipe_ctrl.sv
// mycpu_pipe_ctrl: pipeline control for the five-stage core.
// Turns per-stage stall requests, the multi-cycle execute handshake and
// redirect requests into per-stage stall/flush vectors and a PC redirect.
// Optional performance counters are built when MYCPU_PIPE_PERF_EN is defined.
//
// Handshake: mc_start is a one-cycle launch pulse accepted only in RUN;
// mc_done marks the cycle the multi-cycle result is valid; mc_cancel is a
// one-cycle abort pulse, registered, one cycle after the abort decision.
module mycpu_pipe_ctrl #(
  parameter int NSTAGE      = 6,
  parameter int EX_IDX      = 3,
  parameter int FLUSH_DEPTH = 3,
  parameter int MC_TIMEOUT  = 64,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic              mc_start,
  input  logic              mc_done,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic              new_pc_valid,
  output logic [31:0]       new_pc,
  output logic              mc_cancel,
  output logic              mc_timeout,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count,
  output logic [1:0]        dbg_state
);

  localparam int WD_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [31:0]       pc_q, pc_d;
  logic [NSTAGE-1:0] flush_q, flush_d;
  logic              npv_q, npv_d;
  logic              cancel_q, cancel_d;
  logic              to_q, to_d;
  logic              force_ex;
  logic [NSTAGE-1:0] base_stall, ex_mask, fl_mask;

  // Thermometer base stall plus the fixed EX-hold and flush masks.
  always_comb begin
    base_stall = '0;
    ex_mask    = '0;
    fl_mask    = '0;
    for (int j = 0; j < NSTAGE; j++) begin
      base_stall[j] = |(stallreq >> j);
      ex_mask[j]    = (j <= EX_IDX);
      fl_mask[j]    = (j >= 1) && (j <= FLUSH_DEPTH);
    end
  end

  // Next-state logic; priority is flush > watchdog > mc_done > mc_start.
  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    pc_d     = pc_q;
    cancel_d = 1'b0;
    to_d     = to_q;
    force_ex = 1'b0;
    case (state_q)
      RUN: begin
        if (flush_req) begin
          state_d  = FLUSH;
          pc_d     = flush_pc;
          cancel_d = mc_start;
        end else if (mc_start) begin
          state_d  = MC_WAIT;
          wd_d     = '0;
          force_ex = 1'b1;
        end
      end
      MC_WAIT: begin
        wd_d     = wd_q + WD_W'(1);
        // Release the hold in the done cycle so EX->MEM captures the result.
        force_ex = !mc_done;
        if (flush_req) begin
          state_d  = FLUSH;
          pc_d     = flush_pc;
          cancel_d = 1'b1;
        end else if (wd_q == WD_LAST) begin
          state_d  = RUN;
          cancel_d = 1'b1;
          to_d     = 1'b1;
        end else if (mc_done) begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (flush_req) begin
          state_d = FLUSH;
          pc_d    = flush_pc;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    flush_d = (state_d == FLUSH) ? fl_mask : '0;
    npv_d   = (state_d == FLUSH);
  end

  // Combinational stall: zero during FLUSH and while reset is held.
  always_comb begin
    stall = '0;
    if (rst && (state_q != FLUSH)) begin
      stall = base_stall | (force_ex ? ex_mask : '0);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      wd_q     <= '0;
      pc_q     <= '0;
      flush_q  <= '0;
      npv_q    <= 1'b0;
      cancel_q <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wd_q     <= wd_d;
      pc_q     <= pc_d;
      flush_q  <= flush_d;
      npv_q    <= npv_d;
      cancel_q <= cancel_d;
      to_q     <= to_d;
    end
  end

  assign flush        = flush_q;
  assign new_pc_valid = npv_q;
  assign new_pc       = pc_q;
  assign mc_cancel    = cancel_q;
  assign mc_timeout   = to_q;
  assign dbg_state    = state_q;

`ifdef MYCPU_PIPE_PERF_EN
  logic [CNT_W-1:0] sc_q, sc_d, fc_q, fc_d;

  // Saturating stall-cycle and flush counters.
  always_comb begin
    sc_d = sc_q;
    fc_d = fc_q;
    if (stall[0] && (sc_q != '1)) sc_d = sc_q + CNT_W'(1);
    if ((state_d == FLUSH) && (fc_q != '1)) fc_d = fc_q + CNT_W'(1);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc_q <= '0;
      fc_q <= '0;
    end else begin
      sc_q <= sc_d;
      fc_q <= fc_d;
    end
  end

  assign stall_cycles = sc_q;
  assign flush_count  = fc_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_mycpu_pipe_ctrl.sv
// tb_mycpu_pipe_ctrl: directed bench for mycpu_pipe_ctrl with a scoreboard.
// Each driven cycle pushes its hand-computed expected output record; a
// negedge monitor pops and compares. Honours MYCPU_PIPE_PERF_EN.
module tb_mycpu_pipe_ctrl;
  localparam int CNT_W = 32;
  localparam int W     = 2 + 6 + 6 + 1 + 32 + 1 + 1 + 2 * CNT_W;
  localparam logic [1:0] S_R = 2'd0;
  localparam logic [1:0] S_W = 2'd1;
  localparam logic [1:0] S_F = 2'd2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [5:0]       stallreq = '0;
  logic             mc_start = 1'b0;
  logic             mc_done = 1'b0;
  logic             flush_req = 1'b0;
  logic [31:0]      flush_pc = '0;
  logic [5:0]       stall, flush;
  logic             new_pc_valid, mc_cancel, mc_timeout;
  logic [31:0]      new_pc;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [1:0]       dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] care_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           sc_tally = 0;
  int           fc_tally = 0;

  mycpu_pipe_ctrl #(
    .NSTAGE(6), .EX_IDX(3), .FLUSH_DEPTH(3), .MC_TIMEOUT(64), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .mc_start(mc_start),
    .mc_done(mc_done), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .flush(flush), .new_pc_valid(new_pc_valid),
    .new_pc(new_pc), .mc_cancel(mc_cancel), .mc_timeout(mc_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count),
    .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Drive one cycle of inputs and push the expected outputs for that cycle.
  task automatic cyc(input logic r, input logic [5:0] sr, input logic ms,
                     input logic md, input logic fr, input logic [31:0] fpc,
                     input logic [1:0] es, input logic [5:0] est,
                     input logic [5:0] efl, input logic enpv,
                     input logic [31:0] enpc, input logic ecan,
                     input logic eto, input string nm);
    logic [W-1:0]     e, c;
    logic [CNT_W-1:0] esc, efc;
    @(posedge clk);
    #1;
    rst = r; stallreq = sr; mc_start = ms; mc_done = md;
    flush_req = fr; flush_pc = fpc;
    if (!r) begin
      sc_tally = 0;
      fc_tally = 0;
    end else if (es == S_F) begin
      fc_tally++;
    end
`ifdef MYCPU_PIPE_PERF_EN
    esc = CNT_W'(sc_tally);
    efc = CNT_W'(fc_tally);
`else
    esc = '0;
    efc = '0;
`endif
    e = {es, est, efl, enpv, enpc, ecan, eto, esc, efc};
    c = '1;
    if (!enpv) c[2*CNT_W+2 +: 32] = '0;
    exp_q.push_back(e);
    care_q.push_back(c);
    name_q.push_back(nm);
    if (r && est[0]) sc_tally++;
  endtask

  // Monitor: compare the DUT against the scoreboard once per cycle.
  always @(negedge clk) begin
    logic [W-1:0] got, e, c;
    string        nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      c  = care_q.pop_front();
      nm = name_q.pop_front();
      got = {dbg_state, stall, flush, new_pc_valid, new_pc, mc_cancel,
             mc_timeout, stall_cycles, flush_count};
      n_checks++;
      if ((got & c) !== (e & c)) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", nm, got & c, e & c);
      end
    end
  end

  // Directed stimulus.
  initial begin
    // Reset held with noisy inputs: everything zero.
    cyc(0, 6'h3F, 1, 0, 1, 32'h1234, S_R, 6'h00, 6'h00, 0, 0, 0, 0, "reset_hold");
    cyc(0, 6'h3F, 1, 0, 1, 32'h1234, S_R, 6'h00, 6'h00, 0, 0, 0, 0, "reset_hold2");
    cyc(1, 6'h00, 0, 0, 0, 0, S_R, 6'h00, 6'h00, 0, 0, 0, 0, "reset_release");

    // Thermometer stall.
    for (int i = 0; i < 3; i++)
      cyc(1, 6'h04, 0, 0, 0, 0, S_R, 6'h07, 6'h00, 0, 0, 0, 0, "therm_hold");
    cyc(1, 6'h00, 0, 0, 0, 0, S_R, 6'h00, 6'h00, 0, 0, 0, 0, "therm_drop");
    cyc(1, 6'h21, 0, 0, 0, 0, S_R, 6'h3F, 6'h00, 0, 0, 0, 0, "therm_top");
    cyc(1, 6'h01, 0, 0, 0, 0, S_R, 6'h01, 6'h00, 0, 0, 0, 0, "therm_bit0");

    // Multi-cycle op completing 5 cycles after launch.
    cyc(1, 6'h00, 1, 0, 0, 0, S_R, 6'h0F, 6'h00, 0, 0, 0, 0, "mc_start");
    cyc(1, 6'h00, 0, 0, 0, 0, S_W, 6'h0F, 6'h00, 0, 0, 0, 0, "mc_wait1");
    cyc(1, 6'h10, 0, 0, 0, 0, S_W, 6'h1F, 6'h00, 0, 0, 0, 0, "mc_or_base");
    cyc(1, 6'h00, 0, 0, 0, 0, S_W, 6'h0F, 6'h00, 0, 0, 0, 0, "mc_wait3");
    cyc(1, 6'h00, 0, 0, 0, 0, S_W, 6'h0F, 6'h00, 0, 0, 0, 0, "mc_wait4");
    cyc(1, 6'h00, 0, 1, 0, 0, S_W, 6'h00, 6'h00, 0, 0, 0, 0, "mc_done");
    cyc(1, 6'h00, 0, 0, 0, 0, S_R, 6'h00, 6'h00, 0, 0, 0, 0, "mc_after");

    // Redirect with a pending stall request.
    cyc(1, 6'h08, 0, 0, 1, 32'hBFC0_0100, S_R, 6'h0F, 6'h00, 0, 0, 0, 0, "fl_req");
    cyc(1, 6'h08, 0, 0, 0, 0, S_F, 6'h00, 6'h0E, 1, 32'hBFC0_0100, 0, 0, "fl_cycle");
    cyc(1, 6'h08, 0, 0, 0, 0, S_R, 6'h0F, 6'h00, 0, 0, 0, 0, "fl_after");

    // Back-to-back redirects.
    cyc(1, 6'h00, 0, 0, 1, 32'h1000, S_R, 6'h00, 6'h00, 0, 0, 0, 0, "b2b_req");
    cyc(1, 6'h00, 0, 0, 1, 32'h2000, S_F, 6'h00, 6'h0E, 1, 32'h1000, 0, 0, "b2b_first");
    cyc(1, 6'h00, 0, 0, 0, 0, S_F, 6'h00, 6'h0E, 1, 32'h2000, 0, 0, "b2b_second");
    cyc(1, 6'h00, 0, 0, 0, 0, S_R, 6'h00, 6'h00, 0, 0, 0, 0, "b2b_done");

    // mc_start with flush_req in RUN: flush wins, cancel pulses; mc_start in FLUSH ignored.
    cyc(1, 6'h00, 1, 0, 1, 32'h3000, S_R, 6'h00, 6'h00, 0, 0, 0, 0, "st_fl_req");
    cyc(1, 6'h00, 1, 0, 0, 0, S_F, 6'h00, 6'h0E, 1, 32'h3000, 1, 0, "st_fl_cycle");
    cyc(1, 6'h00, 0, 0, 0, 0, S_R, 6'h00, 6'h00, 0, 0, 0, 0, "st_fl_done");

    // Watchdog abort after 64 MC_WAIT cycles; mc_start mid-wait ignored.
    cyc(1, 6'h00, 1, 0, 0, 0, S_R, 6'h0F, 6'h00, 0, 0, 0, 0, "wd_start");
    for (int k = 1; k <= 64; k++)
      cyc(1, 6'h00, (k == 10), 0, 0, 0, S_W, 6'h0F, 6'h00, 0, 0, 0, 0, "wd_wait");
    cyc(1, 6'h00, 0, 0, 0, 0, S_R, 6'h00, 6'h00, 0, 0, 1, 1, "wd_abort");
    cyc(1, 6'h00, 0, 0, 0, 0, S_R, 6'h00, 6'h00, 0, 0, 0, 1, "wd_sticky");

    // mc_done together with flush_req: flush wins, cancel pulses.
    cyc(1, 6'h00, 1, 0, 0, 0, S_R, 6'h0F, 6'h00, 0, 0, 0, 1, "mf_start");
    cyc(1, 6'h00, 0, 0, 0, 0, S_W, 6'h0F, 6'h00, 0, 0, 0, 1, "mf_wait1");
    cyc(1, 6'h00, 0, 0, 0, 0, S_W, 6'h0F, 6'h00, 0, 0, 0, 1, "mf_wait2");
    cyc(1, 6'h08, 0, 1, 1, 32'h4000, S_W, 6'h0F, 6'h00, 0, 0, 0, 1, "mf_both");
    cyc(1, 6'h00, 0, 0, 0, 0, S_F, 6'h00, 6'h0E, 1, 32'h4000, 1, 1, "mf_flush");
    cyc(1, 6'h00, 0, 0, 0, 0, S_R, 6'h00, 6'h00, 0, 0, 0, 1, "mf_done");

    // Asynchronous reset in the middle of MC_WAIT.
    cyc(1, 6'h00, 1, 0, 0, 0, S_R, 6'h0F, 6'h00, 0, 0, 0, 1, "rs_start");
    cyc(1, 6'h00, 0, 0, 0, 0, S_W, 6'h0F, 6'h00, 0, 0, 0, 1, "rs_wait");
    cyc(0, 6'h3F, 1, 0, 1, 32'h5555, S_R, 6'h00, 6'h00, 0, 0, 0, 0, "rs_assert");
    cyc(1, 6'h00, 0, 0, 0, 0, S_R, 6'h00, 6'h00, 0, 0, 0, 0, "rs_release");
    cyc(1, 6'h02, 0, 0, 0, 0, S_R, 6'h03, 6'h00, 0, 0, 0, 0, "rs_alive");
    cyc(1, 6'h00, 0, 0, 0, 0, S_R, 6'h00, 6'h00, 0, 0, 0, 0, "rs_idle");

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mycpu_pipe_ctrl.md
# mycpu_pipe_ctrl

Parametrised pipeline control unit for the five-stage core. It replaces the fixed CTRL stub that only drives the stall bus from reset. It turns per-stage stall requests, multi-cycle execute handshakes and redirect requests into a per-stage `stall` vector, a per-stage `flush` vector and a PC redirect. It sits beside IF/ID/EX/MEM/WB and feeds their existing `stall` inputs.

## Interface
- `NSTAGE`, 6: stall/flush vector width. Bit 0 is PC, then IF, ID, EX, MEM, WB.
- `EX_IDX`, 3: index of the stage hosting multi-cycle units.
- `FLUSH_DEPTH`, 3: flush clears stages 1..FLUSH_DEPTH.
- `MC_TIMEOUT`, 64: maximum MC_WAIT cycles before abort. Must be ≥2.
- `CNT_W`, 32: performance counter width.

Ports:
- `clk` in 1: clock. One clock; reset is asynchronous and active-low.
- `rst` in 1: asynchronous active-low reset.
- `stallreq` in NSTAGE: combinational hold request. Bit k asks to hold stage k and everything upstream.
- `mc_start` in 1: one-cycle pulse. EX launches a multi-cycle operation.
- `mc_done` in 1: the multi-cycle result is valid this cycle.
- `flush_req` in 1: branch/exception redirect request.
- `flush_pc` in 32: redirect target, sampled with `flush_req`.
- `stall` out NSTAGE: per-stage hold.
- `flush` out NSTAGE: per-stage clear, converting the stage register to a bubble.
- `new_pc_valid` out 1, `new_pc` out 32: PC redirect.
- `mc_cancel` out 1: one-cycle pulse that aborts the multi-cycle unit.
- `mc_timeout` out 1: sticky error flag.
- `stall_cycles` out CNT_W, `flush_count` out CNT_W: performance counters.

## Operation
- FSM states: RUN, MC_WAIT, FLUSH. Reset state is RUN.
- Base stall is thermometer-coded. With k = highest set bit of `stallreq`, stall[j]=1 for j≤k; otherwise stall is zero.
- RUN:
  - `flush_req` → FLUSH. `flush_pc` is latched.
  - Otherwise `mc_start` → MC_WAIT, and stall[0..EX_IDX] is forced high in that same cycle.
- MC_WAIT:
  - stall[0..EX_IDX] is forced high and ORed with the base stall. The watchdog counter increments.
  - `mc_done` → RUN. The forced stall drops in the `mc_done` cycle so the EX→MEM register captures the result.
  - Watchdog reaches MC_TIMEOUT → RUN. `mc_timeout` is set (it stays set until reset) and `mc_cancel` pulses.
  - `flush_req` → FLUSH. `mc_cancel` pulses and `flush_pc` is latched.
- FLUSH, which lasts exactly one cycle:
  - flush[1..FLUSH_DEPTH]=1 and stall=0, overriding `stallreq`.
  - `new_pc_valid`=1 and `new_pc` = latched PC.
  - Next state is RUN. A new `flush_req` in this cycle → FLUSH again with the new PC.
- Priority: `flush_req` > watchdog timeout > `mc_done` > `mc_start`.
  - `mc_start` together with `flush_req` in RUN: flush wins and `mc_cancel` pulses.
  - `mc_done` together with `flush_req` in MC_WAIT: flush wins and the result is discarded.
- `mc_start` while in MC_WAIT or FLUSH is ignored.
- `flush[0]` and flush bits above FLUSH_DEPTH are always 0.

## Timing
- `stall` is combinational from `stallreq`, `mc_start` and the state, with zero latency.
- Every other output is registered.
- Flush latency: `flush_req` at cycle t gives `flush`/`new_pc_valid` at cycle t+1 for exactly one cycle.
- Watchdog:
  - Counter clears on MC_WAIT entry.
  - Timeout fires in the MC_WAIT cycle where count = MC_TIMEOUT-1.
  - `mc_cancel` and `mc_timeout` appear the next cycle.
- Reset (asynchronous, any time, including mid-MC_WAIT or FLUSH):
  - state RUN.
  - `stall`, `flush`, `new_pc`, `new_pc_valid`, `mc_cancel`, `mc_timeout`, `stall_cycles` and `flush_count` all 0.
  - Watchdog cleared.
  - `stall` is 0 while `rst` is low, regardless of inputs.

## Configuration
- `MYCPU_PIPE_PERF_EN` defined:
  - `stall_cycles` increments every cycle with stall[0]=1.
  - `flush_count` increments on each FLUSH entry.
  - Both saturate at all-ones.
- Undefined: both counters are tied to 0 and their registers are not built. All other behaviour is identical.

## Test plan
- `stallreq`=6'b000100 for 3 cycles → stall=6'b000111 for the same 3 cycles, then 0. flush stays 0.
- `mc_start` pulse, `mc_done` 5 cycles later → stall[3:0]=4'b1111 from the start cycle through the cycle before done. stall=0 in the done cycle. No `mc_cancel`.
- `flush_req`=1 with `flush_pc`=32'hBFC0_0100 while `stallreq`=6'b001000 → next cycle flush=6'b001110, stall=0, `new_pc_valid`=1, `new_pc`=32'hBFC0_0100. With the perf macro defined, `flush_count`=1.
- `mc_start` and no `mc_done` for 64 cycles → watchdog aborts. `mc_cancel` pulses once, `mc_timeout`=1 and stays set, and the FSM returns to RUN.
- `flush_req` in the same cycle as `mc_done` during MC_WAIT → FLUSH the next cycle and `mc_cancel` pulses. Assert `rst` low mid-MC_WAIT → all outputs 0 immediately and the FSM is in RUN after release.
